// File: rtl/vtiming_gen.sv
`default_nettype none
// ============================================================================
// vtiming_gen : vertical LCD timing generator (VSW/VBP/LPP/VFP line sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
module vtiming_gen #(
  parameter int CNT_W  = 10,
  parameter int FCNT_W = 8
) (
  input  logic              lineclk,
  input  logic              rst,
  input  logic              lcd_en,
  input  logic [5:0]        vsw,
  input  logic [CNT_W-1:0]  vbp,
  input  logic [CNT_W-1:0]  lpp,
  input  logic [CNT_W-1:0]  vfp,
  input  logic              ivs,
  input  logic [1:0]        vcomp_sel,
  input  logic              vcomp_clr,
  output logic              fp,
  output logic              line_active,
  output logic [CNT_W-1:0]  line_idx,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              frame_done,
  output logic              vcomp_irq,
  output logic              stopped
);

  typedef enum logic [2:0] {
    VRST = 3'd0,
    VSW  = 3'd1,
    VBP  = 3'd2,
    LPP  = 3'd3,
    VFP  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           irq_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] field;
  logic [5:0]       sh_vsw;
  logic [CNT_W-1:0] sh_vbp;
  logic [CNT_W-1:0] sh_lpp;
  logic [CNT_W-1:0] sh_vfp;
  logic             sh_ivs;
  logic [1:0]       sh_sel;
  logic [1:0]       sel_eff;
  logic             last;
  logic             load;
  logic             wrap;
  logic             irq_set;

  always_comb begin
    field = '0;
    case (state)
      VSW:     field = CNT_W'(sh_vsw);
      VBP:     field = sh_vbp;
      LPP:     field = sh_lpp;
      VFP:     field = sh_vfp;
      default: field = '0;
    endcase
  end

  assign last = (cnt == field);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    wrap      = 1'b0;
    case (state)
      VRST: begin
        if (lcd_en) begin
          state_nxt = VSW;
          load      = 1'b1;
        end
      end
      VSW: if (last) state_nxt = VBP;
      VBP: if (last) state_nxt = LPP;
      LPP: if (last) state_nxt = VFP;
      VFP: begin
        if (last) begin
          wrap = 1'b1;
          if (lcd_en) begin
            state_nxt = VSW;
            load      = 1'b1;
          end else begin
            state_nxt = VRST;
          end
        end
      end
      default: state_nxt = VRST;
    endcase
  end

  assign cnt_nxt = ((state == VRST) || last) ? '0 : cnt + CNT_W'(1);

  // A selector being loaded this edge must already govern the VSW entry.
  assign sel_eff = load ? vcomp_sel : sh_sel;

  always_comb begin
    irq_state = VFP;
    case (sel_eff)
      2'd0:    irq_state = VSW;
      2'd1:    irq_state = VBP;
      2'd2:    irq_state = LPP;
      default: irq_state = VFP;
    endcase
  end

  assign irq_set = (state_nxt != state) && (state_nxt == irq_state);

  always_ff @(posedge lineclk or posedge rst) begin
    if (rst) begin
      state <= VRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge lineclk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sh_vsw    <= '0;
      sh_vbp    <= '0;
      sh_lpp    <= '0;
      sh_vfp    <= '0;
      sh_ivs    <= 1'b0;
      sh_sel    <= '0;
      frame_cnt <= '0;
      vcomp_irq <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (load) begin
        sh_vsw <= vsw;
        sh_vbp <= vbp;
        sh_lpp <= lpp;
        sh_vfp <= vfp;
        sh_ivs <= ivs;
        sh_sel <= vcomp_sel;
      end
      if (wrap) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      // Set has priority over a simultaneous clear.
      if (irq_set) begin
        vcomp_irq <= 1'b1;
      end else if (vcomp_clr) begin
        vcomp_irq <= 1'b0;
      end
    end
  end

  assign fp          = (state == VSW) ^ sh_ivs;
  assign line_active = (state == LPP);
  assign line_idx    = (state == LPP) ? cnt : '0;
  assign frame_done  = (state == VFP) && last;
  assign stopped     = (state == VRST);

endmodule
`default_nettype wire
